// File: rtl/lpf_seq_pkg.sv
// lpf_seq_pkg: shared widths, FSM state type and saturation helper for the low-pass frame sequencer
package lpf_seq_pkg;
  localparam int LPF_DATA_W = 16;
  localparam int LPF_COEF_W = 8;
  localparam int LPF_DEFAULT_COEF = 29;
  typedef enum logic [1:0] {IDLE, CALC_L, CALC_R, COMMIT} state_t;
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/lpf_frame_sequencer_if.sv
// lpf_frame_sequencer_if: audio frame, config and filtered output bundle
interface lpf_frame_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 8
);
  logic                  AUD_DACLRCK;
  logic [2*DATA_W-1:0]   currentADCData;
  logic                  cfg_wr;
  logic [COEF_W-1:0]     cfg_coef;
  logic                  cfg_bypass;
  logic [2*DATA_W-1:0]   lowPassFilterOutput;
  logic                  out_valid;
  logic                  busy;
  logic                  overrun;
  modport master (
    output AUD_DACLRCK, currentADCData, cfg_wr, cfg_coef, cfg_bypass,
    input  lowPassFilterOutput, out_valid, busy, overrun
  );
  modport slave (
    input  AUD_DACLRCK, currentADCData, cfg_wr, cfg_coef, cfg_bypass,
    output lowPassFilterOutput, out_valid, busy, overrun
  );
endinterface

// File: rtl/lpf_frame_sequencer_iir_step.sv
// iir_step: combinational first-order IIR step y = y_prev + floor((x - y_prev) * coef / 2^COEF_W), saturated
module iir_step
  import lpf_seq_pkg::*;
#(
  parameter int DATA_W = LPF_DATA_W,
  parameter int COEF_W = LPF_COEF_W
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y_prev,
  input  logic        [COEF_W-1:0] coef,
  input  logic                     bypass,
  output logic signed [DATA_W-1:0] y
);
  logic signed [DATA_W:0]          diff;
  logic signed [DATA_W+COEF_W+1:0] prod;
  logic signed [DATA_W+COEF_W+1:0] step;
  logic signed [31:0]              sum;
  always_comb begin
    diff = {x[DATA_W-1], x} - {y_prev[DATA_W-1], y_prev};
    prod = diff * $signed({1'b0, coef});
    step = prod >>> COEF_W;
    sum  = 32'(y_prev) + 32'(step);
    y    = bypass ? x : DATA_W'(sat(sum, DATA_W));
  end
endmodule

// File: rtl/lpf_frame_sequencer.sv
// lpf_frame_sequencer: per-frame stereo low-pass sequencer sharing one IIR step unit across L then R
module lpf_frame_sequencer
  import lpf_seq_pkg::*;
#(
  parameter int          DATA_W       = LPF_DATA_W,
  parameter int          COEF_W       = LPF_COEF_W,
  parameter int unsigned DEFAULT_COEF = LPF_DEFAULT_COEF
) (
  input logic                  AUDIO_CLK,
  input logic                  rst,
  lpf_frame_sequencer_if.slave bus
);
  state_t                     state_q, state_d;
  logic                       lrck_q;
  logic                       start, idle_start, commit;
  logic [2*DATA_W-1:0]        x_q, x_d;
  logic [2*DATA_W-1:0]        filt_q, filt_d;
  logic signed [DATA_W-1:0]   res_l_q, res_l_d, res_r_q, res_r_d;
  logic                       valid_q, busy_q, busy_d, overrun_q, overrun_d;
  logic [COEF_W-1:0]          coef_pend_q, coef_pend_d, coef_act_q, coef_act_d;
  logic                       byp_pend_q, byp_pend_d, byp_act_q, byp_act_d;
  logic signed [DATA_W-1:0]   step_x, step_y_prev, step_y;
  iir_step #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_step (
    .x      (step_x),
    .y_prev (step_y_prev),
    .coef   (coef_act_q),
    .bypass (byp_act_q),
    .y      (step_y)
  );
  always_comb begin
    start       = bus.AUD_DACLRCK & ~lrck_q;
    idle_start  = start && state_q == IDLE;
    commit      = state_q == COMMIT;
    state_d     = idle_start ? CALC_L : state_q == CALC_L ? CALC_R : state_q == CALC_R ? COMMIT : IDLE;
    step_x      = state_q == CALC_R ? x_q[DATA_W-1:0] : x_q[2*DATA_W-1:DATA_W];
    step_y_prev = state_q == CALC_R ? filt_q[DATA_W-1:0] : filt_q[2*DATA_W-1:DATA_W];
    x_d         = idle_start ? bus.currentADCData : x_q;
    coef_pend_d = bus.cfg_wr ? bus.cfg_coef : coef_pend_q;
    byp_pend_d  = bus.cfg_wr ? bus.cfg_bypass : byp_pend_q;
    coef_act_d  = idle_start ? coef_pend_d : coef_act_q;
    byp_act_d   = idle_start ? byp_pend_d : byp_act_q;
    res_l_d     = state_q == CALC_L ? step_y : res_l_q;
    res_r_d     = state_q == CALC_R ? step_y : res_r_q;
    filt_d      = commit ? {res_l_q, res_r_q} : filt_q;
    busy_d      = state_d != IDLE;
    overrun_d   = overrun_q | (start && state_q != IDLE);
  end
  always_ff @(posedge AUDIO_CLK)
    if (rst) begin
      state_q     <= IDLE;
      lrck_q      <= 1'b0;
      x_q         <= '0;
      filt_q      <= '0;
      res_l_q     <= '0;
      res_r_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      coef_pend_q <= COEF_W'(DEFAULT_COEF);
      coef_act_q  <= COEF_W'(DEFAULT_COEF);
      byp_pend_q  <= 1'b0;
      byp_act_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lrck_q      <= bus.AUD_DACLRCK;
      x_q         <= x_d;
      filt_q      <= filt_d;
      res_l_q     <= res_l_d;
      res_r_q     <= res_r_d;
      valid_q     <= commit;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      coef_pend_q <= coef_pend_d;
      coef_act_q  <= coef_act_d;
      byp_pend_q  <= byp_pend_d;
      byp_act_q   <= byp_act_d;
    end
  assign bus.lowPassFilterOutput = filt_q;
  assign bus.out_valid           = valid_q;
  assign bus.busy                = busy_q;
  assign bus.overrun             = overrun_q;
endmodule

// File: tb/tb_lpf_frame_sequencer.sv
// tb_lpf_frame_sequencer: scoreboard bench for the low-pass frame sequencer
module tb_lpf_frame_sequencer;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_valid = 0;
  exp_t sb[$];
  logic [31:0] m_state = '0;
  logic [7:0] m_coef = 8'd29;
  logic m_byp = 1'b0;
  logic [7:0] p_coef = 8'd29;
  logic p_byp = 1'b0;
  lpf_frame_sequencer_if #(.DATA_W(16), .COEF_W(8)) bus ();
  lpf_frame_sequencer #(.DATA_W(16), .COEF_W(8), .DEFAULT_COEF(29)) dut (
    .AUDIO_CLK (clk),
    .rst       (rst),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] mstep(input logic [15:0] x, input logic [15:0] y);
    int xi;
    int yi;
    int s;
    xi = int'($signed(x));
    yi = int'($signed(y));
    s = yi + (((xi - yi) * int'(m_coef)) >>> 8);
    s = s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
    return m_byp ? x : s[15:0];
  endfunction
  function automatic logic [31:0] model(input logic [31:0] d);
    return {mstep(d[31:16], m_state[31:16]), mstep(d[15:0], m_state[15:0])};
  endfunction
  always @(negedge clk)
    if (!rst && bus.out_valid) begin
      n_valid++;
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", bus.lowPassFilterOutput, e.data);
        check("latency", cyc, e.cyc);
      end
    end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.AUD_DACLRCK = 1'b0;
    bus.cfg_wr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_state = '0;
    p_coef = 8'd29;
    p_byp = 1'b0;
    sb.delete();
  endtask
  task automatic cfg(input logic [7:0] c, input logic b);
    @(negedge clk);
    bus.cfg_wr = 1'b1;
    bus.cfg_coef = c;
    bus.cfg_bypass = b;
    p_coef = c;
    p_byp = b;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
  endtask
  task automatic send(input logic [31:0] d, input logic use_model, input logic [31:0] k);
    logic [31:0] e;
    @(negedge clk);
    m_coef = p_coef;
    m_byp = p_byp;
    e = use_model ? model(d) : k;
    m_state = e;
    sb.push_back('{e, cyc + 4});
    bus.AUD_DACLRCK = 1'b1;
    bus.currentADCData = d;
    @(negedge clk);
    bus.AUD_DACLRCK = 1'b0;
    check("busy_in_frame", bus.busy, 1);
  endtask
  task automatic wait_done();
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy) break;
    end
    @(negedge clk);
    check("drain_timeout", i < 20, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int v0;
    bus.AUD_DACLRCK = 1'b0;
    bus.currentADCData = '0;
    bus.cfg_wr = 1'b0;
    bus.cfg_coef = '0;
    bus.cfg_bypass = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_out", bus.lowPassFilterOutput, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    cfg(8'd128, 1'b0);
    send(32'h03E8_FC18, 0, 32'h01F4_FE0C);
    wait_done();
    send(32'h03E8_FC18, 0, 32'h02EE_FD12);
    wait_done();
    check("held_out", bus.lowPassFilterOutput, 32'h02EE_FD12);
    do_reset();
    cfg(8'd255, 1'b0);
    send(32'h7FFF_8000, 0, 32'h7F7F_8080);
    wait_done();
    send(32'h1234_ABCD, 1, 32'h0);
    cfg(8'd255, 1'b1);
    wait_done();
    send(32'h1234_ABCD, 0, 32'h1234_ABCD);
    wait_done();
    cfg(8'd64, 1'b0);
    send(32'h0100_FF00, 1, 32'h0);
    repeat (2) @(negedge clk);
    send(32'h2000_E000, 1, 32'h0);
    wait_done();
    check("spacing4_no_overrun", bus.overrun, 0);
    for (int i = 0; i < 8; i++) begin
      cfg(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      send($urandom, 1, 32'h0);
      wait_done();
    end
    do_reset();
    v0 = n_valid;
    send(32'h03E8_0000, 1, 32'h0);
    @(negedge clk);
    bus.AUD_DACLRCK = 1'b1;
    bus.currentADCData = 32'h5555_5555;
    @(negedge clk);
    bus.AUD_DACLRCK = 1'b0;
    wait_done();
    check("overrun_set", bus.overrun, 1);
    check("one_valid", n_valid - v0, 1);
    send(32'h0000_0100, 1, 32'h0);
    wait_done();
    check("overrun_sticky", bus.overrun, 1);
    cfg(8'd200, 1'b0);
    v0 = n_valid;
    @(negedge clk);
    bus.AUD_DACLRCK = 1'b1;
    bus.currentADCData = 32'h4000_4000;
    @(negedge clk);
    bus.AUD_DACLRCK = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    m_state = '0;
    p_coef = 8'd29;
    p_byp = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_valid", n_valid - v0, 0);
    check("abort_out", bus.lowPassFilterOutput, 0);
    check("abort_idle", bus.busy, 0);
    check("overrun_cleared", bus.overrun, 0);
    send(32'h03E8_0000, 0, 32'h0071_0000);
    wait_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lpf_frame_sequencer.md
# lpf_frame_sequencer

Frame-rate controller for the audio low-pass path. On each rising edge of `AUD_DACLRCK` it captures the packed stereo ADC word and drives one shared first-order IIR step unit, left channel then right. It then commits the filtered pair as the new filter state and presents it to the DAC side. Coefficient and bypass settings are programmable and applied atomically at frame boundaries.

## Interface
- `DATA_W`, 16: per-channel sample width; the packed word is 2*DATA_W, left in the upper half.
- `COEF_W`, 8: unsigned fractional coefficient width; alpha = coef / 2^COEF_W.
- `DEFAULT_COEF`, 29: coefficient after reset (≈0.113).
- `AUDIO_CLK` in 1: sole clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `AUD_DACLRCK` in 1: frame clock, sampled in `AUDIO_CLK`; its rising edge starts a frame.
- `currentADCData` in 2*DATA_W: stereo input `{L,R}`, two's complement.
- `cfg_wr` in 1: one-cycle strobe that captures `cfg_coef` and `cfg_bypass`.
- `cfg_coef` in COEF_W: new coefficient.
- `cfg_bypass` in 1: 1 = output equals input.
- `lowPassFilterOutput` out 2*DATA_W: filtered `{L,R}`, registered, held between frames.
- `out_valid` out 1: one-cycle pulse when `lowPassFilterOutput` updates.
- `busy` out 1: high while the FSM is not in IDLE.
- `overrun` out 1: sticky; set when a frame edge arrives while busy.

## Operation
- Edge detect: `lrck_q` is registered `AUD_DACLRCK`; `start = AUD_DACLRCK & ~lrck_q`.
- FSM states: IDLE → CALC_L → CALC_R → COMMIT → IDLE.
  - IDLE with `start`: latch `currentADCData` into `x_reg`, copy pending config to active config, go to CALC_L.
  - `start` in any other state: the edge is ignored and `overrun` is set.
- The shared step unit computes y = y_prev + ((x − y_prev) * coef >>> COEF_W):
  - diff is DATA_W+1 signed.
  - The product uses coef zero-extended as signed.
  - The shift is arithmetic (floor).
  - The sum is DATA_W+1 and saturates to the DATA_W signed range.
- If active bypass is 1, y = x.
- If coef = 0 and bypass is 0, y = y_prev.
- CALC_L: operands are `x_reg` L and state L; the result goes to `res_l`. CALC_R does the same for R into `res_r`.
- COMMIT: state ← `{res_l,res_r}`, `lowPassFilterOutput` ← `{res_l,res_r}`, `out_valid` ← 1 for the next cycle.
- Config: `cfg_wr` loads the pending registers in any state. Pending values reach the active registers only at frame start. A `cfg_wr` in the same cycle as `start` is used by that frame.
- Reset values:
  - State, `lrck_q`, `x_reg`, `res_l`/`res_r`, `lowPassFilterOutput`: 0.
  - `out_valid`, `busy`, `overrun`: 0.
  - FSM: IDLE.
  - Pending and active coef = DEFAULT_COEF; bypass = 0.
- Reset mid-frame aborts the frame, produces no `out_valid`, and clears the state to 0.
- `overrun` clears only on reset.

## Timing
- Cycle 0: `start` is seen. Cycles 1/2/3: CALC_L/CALC_R/COMMIT.
- `lowPassFilterOutput` and `out_valid` change at the start of cycle 4; the FSM is IDLE in cycle 4.
- Latency from edge detection to output: 4 cycles.
- `busy` is high in cycles 1–3.
- Minimum frame spacing is 4 cycles: a `start` in cycle 4 is accepted without overrun.
- `AUD_DACLRCK` is synchronous to `AUDIO_CLK`; no synchronizer is inside this block.

## Structure
- Package `lpf_seq_pkg` holds:
  - the FSM state enum (IDLE, CALC_L, CALC_R, COMMIT);
  - DATA_W/COEF_W defaults and DEFAULT_COEF;
  - the saturation helper function.
- Sub-module `iir_step`: combinational single-channel step (x, y_prev, coef, bypass → y). It is instantiated once and muxed between channels by the FSM.

## Test plan
- Reset, then `cfg_wr` with coef=128, bypass=0. Frame with input 0x03E8_FC18 (L=1000, R=−1000) → output 0x01F4_FE0C (500/−500), 4 cycles after `start`. Same input on the next frame → 0x02EE_FD12 (750/−750).
- Coef=255 from zero state, input 0x7FFF_8000 → output 0x7F7F_8080 (32639/−32640).
- `cfg_bypass`=1 written while busy: the current frame is still filtered; the next frame, input 0x1234_ABCD → output 0x1234_ABCD.
- Two `AUD_DACLRCK` rising edges 2 cycles apart → one `out_valid` pulse, `overrun`=1 and stays 1 until `rst`.
- `rst` asserted during CALC_R → no `out_valid`, output 0, FSM IDLE. The next frame with 0x03E8_0000 at coef=29 → L = 1000*29>>>8 = 113, output 0x0071_0000.
